// File: rtl/weight_mem_stream_loader.sv
// rtl/weight_mem_stream_loader.sv - packs a byte stream into weight-memory words for the CNN or FC write port
module weight_mem_stream_loader #(
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int N_DIM_ARRAY       = 4,
  parameter int ADDR_W            = 14,
  parameter int LEN_W             = 15
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   target_fc,
  input  logic [ADDR_W-1:0]                      base_addr,
  input  logic [LEN_W-1:0]                       num_words,
  input  logic                                   in_valid,
  input  logic [WEIGHT_DATA_WIDTH-1:0]           in_data,
  output logic                                   in_ready,
  output logic                                   wr_enable_cnn,
  output logic [ADDR_W-1:0]                      wr_addr_cnn,
  output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_cnn,
  output logic                                   wr_enable_fc,
  output logic [ADDR_W-1:0]                      wr_addr_fc,
  output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_fc,
  output logic                                   busy,
  output logic                                   done,
  output logic [LEN_W-1:0]                       words_written
);

  localparam int WORD_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
  localparam int LANE_W = (N_DIM_ARRAY > 1) ? $clog2(N_DIM_ARRAY) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_DIM_ARRAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                target_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    num_q;
  logic [LEN_W-1:0]    word_idx_q;
  logic [LEN_W-1:0]    words_written_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WORD_W-1:0]   pack_q;
  logic                wr_en_cnn_q;
  logic [ADDR_W-1:0]   wr_addr_cnn_q;
  logic [WORD_W-1:0]   wr_data_cnn_q;
  logic                wr_en_fc_q;
  logic [ADDR_W-1:0]   wr_addr_fc_q;
  logic [WORD_W-1:0]   wr_data_fc_q;
  logic                done_q;

  logic                accept;
  logic [WORD_W-1:0]   word_d;
  logic [LEN_W-1:0]    word_idx_d;
  logic [ADDR_W-1:0]   addr_d;

  assign in_ready   = (state_q == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign word_idx_d = word_idx_q + LEN_W'(1);
  // Address wraps naturally at 2^ADDR_W; only the low bits of the word index matter.
  assign addr_d     = base_q + word_idx_q[ADDR_W-1:0];

  // Merge the incoming byte into the partial word; first byte of a word lands in the MSB lane.
  always_comb begin
    word_d = pack_q;
    word_d[(N_DIM_ARRAY - 1 - int'(lane_q)) * WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH] = in_data;
  end

  // Command FSM with registered write strobes; strobes, address and data default to 0 each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      target_q        <= 1'b0;
      base_q          <= '0;
      num_q           <= '0;
      word_idx_q      <= '0;
      words_written_q <= '0;
      lane_q          <= '0;
      pack_q          <= '0;
      wr_en_cnn_q     <= 1'b0;
      wr_addr_cnn_q   <= '0;
      wr_data_cnn_q   <= '0;
      wr_en_fc_q      <= 1'b0;
      wr_addr_fc_q    <= '0;
      wr_data_fc_q    <= '0;
      done_q          <= 1'b0;
    end else begin
      wr_en_cnn_q   <= 1'b0;
      wr_addr_cnn_q <= '0;
      wr_data_cnn_q <= '0;
      wr_en_fc_q    <= 1'b0;
      wr_addr_fc_q  <= '0;
      wr_data_fc_q  <= '0;
      done_q        <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Abort beats any strobe that would have been registered this cycle.
        state_q <= S_IDLE;
        lane_q  <= '0;
        pack_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              words_written_q <= '0;
              word_idx_q      <= '0;
              lane_q          <= '0;
              pack_q          <= '0;
              if (num_words != '0) begin
                target_q <= target_fc;
                base_q   <= base_addr;
                num_q    <= num_words;
                state_q  <= S_LOAD;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              if (lane_q == LAST_LANE) begin
                if (target_q) begin
                  wr_en_fc_q   <= 1'b1;
                  wr_addr_fc_q <= addr_d;
                  wr_data_fc_q <= word_d;
                end else begin
                  wr_en_cnn_q   <= 1'b1;
                  wr_addr_cnn_q <= addr_d;
                  wr_data_cnn_q <= word_d;
                end
                word_idx_q      <= word_idx_d;
                words_written_q <= words_written_q + LEN_W'(1);
                lane_q          <= '0;
                pack_q          <= '0;
                if (word_idx_d == num_q) state_q <= S_DRAIN;
              end else begin
                pack_q <= word_d;
                lane_q <= lane_q + LANE_W'(1);
              end
            end
          end
          S_DRAIN: begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_enable_cnn = wr_en_cnn_q;
  assign wr_addr_cnn   = wr_addr_cnn_q;
  assign wr_data_cnn   = wr_data_cnn_q;
  assign wr_enable_fc  = wr_en_fc_q;
  assign wr_addr_fc    = wr_addr_fc_q;
  assign wr_data_fc    = wr_data_fc_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_weight_mem_stream_loader.sv
// tb/tb_weight_mem_stream_loader.sv - directed self-checking bench for weight_mem_stream_loader
module tb_weight_mem_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        target_fc;
  logic [13:0] base_addr;
  logic [14:0] num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_enable_cnn;
  logic [13:0] wr_addr_cnn;
  logic [31:0] wr_data_cnn;
  logic        wr_enable_fc;
  logic [13:0] wr_addr_fc;
  logic [31:0] wr_data_fc;
  logic        busy;
  logic        done;
  logic [14:0] words_written;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_mem_stream_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .target_fc     (target_fc),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .wr_enable_cnn (wr_enable_cnn),
    .wr_addr_cnn   (wr_addr_cnn),
    .wr_data_cnn   (wr_data_cnn),
    .wr_enable_fc  (wr_enable_fc),
    .wr_addr_fc    (wr_addr_fc),
    .wr_data_fc    (wr_data_fc),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnn(input string tag, input logic en, input logic [13:0] a, input logic [31:0] d);
    chk({tag, ".cnn_en"}, 64'(wr_enable_cnn), 64'(en));
    chk({tag, ".cnn_addr"}, 64'(wr_addr_cnn), 64'(a));
    chk({tag, ".cnn_data"}, 64'(wr_data_cnn), 64'(d));
  endtask

  task automatic chk_fc(input string tag, input logic en, input logic [13:0] a, input logic [31:0] d);
    chk({tag, ".fc_en"}, 64'(wr_enable_fc), 64'(en));
    chk({tag, ".fc_addr"}, 64'(wr_addr_fc), 64'(a));
    chk({tag, ".fc_data"}, 64'(wr_data_fc), 64'(d));
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic bsy, input logic dn);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    chk({tag, ".done"}, 64'(done), 64'(dn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic fc, input logic [13:0] base, input logic [14:0] n);
    start     = 1'b1;
    target_fc = fc;
    base_addr = base;
    num_words = n;
    step();
    start     = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  int gaps [8] = '{0, 2, 1, 0, 3, 0, 1, 2};

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; target_fc = 1'b0;
    base_addr = '0; num_words = '0; in_valid = 1'b0; in_data = '0;
    step();
    step();
    chk_cnn("rst", 1'b0, 14'h0, 32'h0);
    chk_fc("rst", 1'b0, 14'h0, 32'h0);
    chk_status("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.ww", 64'(words_written), 64'd0);
    reset = 1'b1;
    step();

    // CNN load, back-to-back bytes
    start_cmd(1'b0, 14'h0010, 15'd2);
    chk_status("t1.load", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      push(8'(i + 1));
      if (i == 3) chk_cnn("t1.w0", 1'b1, 14'h0010, 32'h01020304);
      else if (i == 7) chk_cnn("t1.w1", 1'b1, 14'h0011, 32'h05060708);
      else chk_cnn("t1.quiet", 1'b0, 14'h0, 32'h0);
      chk_fc("t1.fc", 1'b0, 14'h0, 32'h0);
    end
    chk_status("t1.drain", 1'b0, 1'b1, 1'b0);
    chk("t1.ww", 64'(words_written), 64'd2);
    step();
    chk_status("t1.done", 1'b0, 1'b1, 1'b1);
    chk_cnn("t1.done", 1'b0, 14'h0, 32'h0);
    step();
    chk_status("t1.idle", 1'b0, 1'b0, 1'b0);

    // FC load with address wrap
    start_cmd(1'b1, 14'h3FFF, 15'd2);
    push(8'hF0); push(8'hF1); push(8'hF2); push(8'hF3);
    chk_fc("t2.w0", 1'b1, 14'h3FFF, 32'hF0F1F2F3);
    chk_cnn("t2.cnn", 1'b0, 14'h0, 32'h0);
    push(8'h80); push(8'h81); push(8'h7F); push(8'h00);
    chk_fc("t2.w1", 1'b1, 14'h0000, 32'h80817F00);
    chk("t2.ww", 64'(words_written), 64'd2);
    step();
    chk_status("t2.done", 1'b0, 1'b1, 1'b1);
    step();

    // Gapped stream gives the same words as back-to-back
    start_cmd(1'b0, 14'h0010, 15'd2);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
        chk_cnn("t3.gap", 1'b0, 14'h0, 32'h0);
        chk("t3.gap_rdy", 64'(in_ready), 64'd1);
      end
      push(8'(i + 1));
      if (i == 3) chk_cnn("t3.w0", 1'b1, 14'h0010, 32'h01020304);
      else if (i == 7) chk_cnn("t3.w1", 1'b1, 14'h0011, 32'h05060708);
      else chk_cnn("t3.quiet", 1'b0, 14'h0, 32'h0);
    end
    chk_status("t3.drain", 1'b0, 1'b1, 1'b0);
    step();
    chk_status("t3.done", 1'b0, 1'b1, 1'b1);
    step();
    chk_status("t3.idle", 1'b0, 1'b0, 1'b0);

    // Zero-length command; start during DONE ignored
    start_cmd(1'b0, 14'h0005, 15'd0);
    chk_status("t4.done", 1'b0, 1'b1, 1'b1);
    chk_cnn("t4", 1'b0, 14'h0, 32'h0);
    chk_fc("t4", 1'b0, 14'h0, 32'h0);
    start_cmd(1'b0, 14'h0005, 15'd3);
    chk_status("t4.idle", 1'b0, 1'b0, 1'b0);
    step();
    chk_status("t4.still_idle", 1'b0, 1'b0, 1'b0);

    // Abort after 6 bytes of a 3-word load; start during LOAD ignored
    start_cmd(1'b0, 14'h0020, 15'd3);
    start = 1'b1; base_addr = 14'h0000; num_words = 15'd1;
    push(8'h11);
    start = 1'b0;
    push(8'h12); push(8'h13); push(8'h14);
    chk_cnn("t5.w0", 1'b1, 14'h0020, 32'h11121314);
    push(8'h15); push(8'h16);
    chk_status("t5.pre", 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_status("t5.abort", 1'b0, 1'b0, 1'b0);
    chk_cnn("t5.abort", 1'b0, 14'h0, 32'h0);
    chk("t5.ww", 64'(words_written), 64'd1);
    step();
    chk_status("t5.nodone", 1'b0, 1'b0, 1'b0);

    // Abort coinciding with the final byte cancels that strobe
    start_cmd(1'b0, 14'h0030, 15'd1);
    push(8'h21); push(8'h22); push(8'h23);
    abort = 1'b1;
    push(8'h24);
    abort = 1'b0;
    chk_cnn("t5.cancel", 1'b0, 14'h0, 32'h0);
    chk_status("t5.cancel", 1'b0, 1'b0, 1'b0);
    chk("t5.cancel_ww", 64'(words_written), 64'd0);

    // Normal command after abort
    start_cmd(1'b1, 14'h0031, 15'd1);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    chk_fc("t5.after", 1'b1, 14'h0031, 32'h41424344);
    chk("t5.after_ww", 64'(words_written), 64'd1);
    step();
    chk_status("t5.after_done", 1'b0, 1'b1, 1'b1);
    step();

    // Asynchronous reset while a strobe is on the FC port
    start_cmd(1'b1, 14'h0040, 15'd2);
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    chk_fc("t6.pre", 1'b1, 14'h0040, 32'h51525354);
    #2;
    reset = 1'b0;
    #1;
    chk_fc("t6.async", 1'b0, 14'h0, 32'h0);
    chk_status("t6.async", 1'b0, 1'b0, 1'b0);
    chk("t6.ww", 64'(words_written), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk_status("t6.post", 1'b0, 1'b0, 1'b0);
    chk_fc("t6.post", 1'b0, 14'h0, 32'h0);
    start_cmd(1'b0, 14'h0050, 15'd1);
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    chk_cnn("t6.load", 1'b1, 14'h0050, 32'h61626364);
    step();
    chk_status("t6.done", 1'b0, 1'b1, 1'b1);
    step();
    chk_status("t6.idle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
